// File: rtl/lcd_fb_pkg.sv
// Shared geometry, display FSM encoding and address helpers for the LCD framebuffer scheduler.
package lcd_fb_pkg;

    localparam int unsigned FB_W     = 60;
    localparam int unsigned FB_H     = 32;
    localparam int unsigned FB_DEPTH = 1920;
    localparam int unsigned ADDR_W   = 11;
    localparam int unsigned COLOR_W  = 4;
    localparam int unsigned COORD_W  = 6;

    typedef enum logic [1:0] {
        StBoot,
        StIdle,
        StScan,
        StGap
    } disp_state_e;

    // Linear address y*60+x; only meaningful when fb_in_range() holds.
    function automatic logic [ADDR_W-1:0] fb_addr(input logic [COORD_W-1:0] x,
                                                  input logic [COORD_W-1:0] y);
        return ADDR_W'(y) * ADDR_W'(FB_W) + ADDR_W'(x);
    endfunction

    function automatic logic fb_in_range(input logic [COORD_W-1:0] x,
                                         input logic [COORD_W-1:0] y);
        return (32'(x) < FB_W) && (32'(y) < FB_H);
    endfunction

endpackage

// File: rtl/lcd_fb_ram.sv
// 1920x4 framebuffer: one synchronous write port, one asynchronous read port, zero at power-up.
module lcd_fb_ram
    import lcd_fb_pkg::*;
(
    input  logic               clk,
    input  logic               we,
    input  logic [ADDR_W-1:0]  waddr,
    input  logic [COLOR_W-1:0] wdata,
    input  logic [ADDR_W-1:0]  raddr,
    output logic [COLOR_W-1:0] rdata
);

    logic [COLOR_W-1:0] mem [FB_DEPTH] = '{default: '0};

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/lcd_fb_scheduler.sv
// Framebuffer owner between CPU and SPI LCD streamer: pixel writes, bulk clear and
// sequencing of the streamer's update pulse around LCD init and frame scans.
module lcd_fb_scheduler
    import lcd_fb_pkg::*;
#(
    parameter int unsigned INIT_CYCLES  = 11_400_000,
    parameter int unsigned FRAME_CYCLES = 550_802,
    parameter int unsigned MIN_GAP      = 0,
    parameter bit          LOCK_SCAN    = 1'b0,
    parameter bit          AUTO_COMMIT  = 1'b0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cpu_we,
    input  logic               cpu_clear,
    input  logic [COORD_W-1:0] cpu_x,
    input  logic [COORD_W-1:0] cpu_y,
    input  logic [COLOR_W-1:0] cpu_color,
    input  logic               cpu_commit,
    output logic               cpu_ready,
    input  logic [COORD_W-1:0] lcd_x,
    input  logic [COORD_W-1:0] lcd_y,
    output logic [COLOR_W-1:0] lcd_frame,
    output logic               lcd_update,
    output logic               busy,
    output logic [7:0]         frame_count
);

    disp_state_e        state;
    logic [31:0]        cnt;
    logic               pending;
    logic               clearing;
    logic [ADDR_W-1:0]  clr_addr;
    logic [COLOR_W-1:0] clr_color;

    logic               clear_acc, write_acc, clear_last;
    logic               pend_next, clear_next, idle_next, fire_next;
    logic               ram_we;
    logic [ADDR_W-1:0]  ram_waddr;
    logic [COLOR_W-1:0] ram_wdata, ram_rdata;

    always_comb begin
        cpu_ready  = ~rst & ~clearing & ~(LOCK_SCAN && state == StScan);
        clear_acc  = cpu_clear & cpu_ready;
        write_acc  = cpu_we & cpu_ready & ~cpu_clear;
        clear_last = clearing && (clr_addr == ADDR_W'(FB_DEPTH - 1));
        clear_next = clear_acc | (clearing & ~clear_last);
        // A new request in the pulse cycle survives the clear.
        pend_next  = cpu_commit | (AUTO_COMMIT & (clear_acc | write_acc))
                   | (pending & ~lcd_update);

        idle_next = 1'b0;
        case (state)
            StBoot:  idle_next = (cnt == INIT_CYCLES - 1);
            StIdle:  idle_next = ~lcd_update;
            StScan:  idle_next = (cnt == FRAME_CYCLES - 1) && (MIN_GAP == 0);
            StGap:   idle_next = (cnt == MIN_GAP - 1);
            default: idle_next = 1'b0;
        endcase
        // The pulse is registered so it coincides with the first eligible idle cycle.
        fire_next = idle_next & pend_next & ~clear_next;

        busy = (state != StIdle) | clearing | lcd_update;

        ram_we    = ~rst & (clearing | (write_acc & fb_in_range(cpu_x, cpu_y)));
        ram_waddr = clearing ? clr_addr  : fb_addr(cpu_x, cpu_y);
        ram_wdata = clearing ? clr_color : cpu_color;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= StBoot;
            cnt         <= '0;
            pending     <= 1'b0;
            clearing    <= 1'b0;
            clr_addr    <= '0;
            clr_color   <= '0;
            lcd_update  <= 1'b0;
            frame_count <= '0;
        end else begin
            pending    <= pend_next;
            clearing   <= clear_next;
            lcd_update <= fire_next;
            if (fire_next) begin
                frame_count <= frame_count + 8'd1;
            end
            if (clear_acc) begin
                clr_addr  <= '0;
                clr_color <= cpu_color;
            end else if (clearing) begin
                clr_addr <= clr_addr + ADDR_W'(1);
            end

            case (state)
                StBoot: begin
                    if (cnt == INIT_CYCLES - 1) begin
                        state <= StIdle;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end
                StIdle: begin
                    if (lcd_update) begin
                        state <= StScan;
                        cnt   <= '0;
                    end
                end
                StScan: begin
                    if (cnt == FRAME_CYCLES - 1) begin
                        state <= (MIN_GAP != 0) ? StGap : StIdle;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end
                StGap: begin
                    if (cnt == MIN_GAP - 1) begin
                        state <= StIdle;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end
                default: begin
                    state <= StBoot;
                    cnt   <= '0;
                end
            endcase
        end
    end

    lcd_fb_ram u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (ram_waddr),
        .wdata (ram_wdata),
        .raddr (fb_addr(lcd_x, lcd_y)),
        .rdata (ram_rdata)
    );

    assign lcd_frame = fb_in_range(lcd_x, lcd_y) ? ram_rdata : '0;

endmodule

// File: tb/tb_lcd_fb_scheduler.sv
// Directed bench for lcd_fb_scheduler with short init/frame/gap timings.
module tb_lcd_fb_scheduler;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, cpu_we, cpu_clear, cpu_commit, cpu_ready, lcd_update, busy;
    logic [5:0] cpu_x, cpu_y, lcd_x, lcd_y;
    logic [3:0] cpu_color, lcd_frame;
    logic [7:0] frame_count;

    logic       l_rst, l_cpu_we, l_cpu_clear, l_cpu_commit, l_cpu_ready, l_lcd_update, l_busy;
    logic [5:0] l_cpu_x, l_cpu_y, l_lcd_x, l_lcd_y;
    logic [3:0] l_cpu_color, l_lcd_frame;
    logic [7:0] l_frame_count;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    lcd_fb_scheduler #(
        .INIT_CYCLES  (10),
        .FRAME_CYCLES (20),
        .MIN_GAP      (5),
        .LOCK_SCAN    (1'b0),
        .AUTO_COMMIT  (1'b0)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .cpu_we      (cpu_we),
        .cpu_clear   (cpu_clear),
        .cpu_x       (cpu_x),
        .cpu_y       (cpu_y),
        .cpu_color   (cpu_color),
        .cpu_commit  (cpu_commit),
        .cpu_ready   (cpu_ready),
        .lcd_x       (lcd_x),
        .lcd_y       (lcd_y),
        .lcd_frame   (lcd_frame),
        .lcd_update  (lcd_update),
        .busy        (busy),
        .frame_count (frame_count)
    );

    lcd_fb_scheduler #(
        .INIT_CYCLES  (10),
        .FRAME_CYCLES (20),
        .MIN_GAP      (5),
        .LOCK_SCAN    (1'b1),
        .AUTO_COMMIT  (1'b0)
    ) dut_lock (
        .clk         (clk),
        .rst         (l_rst),
        .cpu_we      (l_cpu_we),
        .cpu_clear   (l_cpu_clear),
        .cpu_x       (l_cpu_x),
        .cpu_y       (l_cpu_y),
        .cpu_color   (l_cpu_color),
        .cpu_commit  (l_cpu_commit),
        .cpu_ready   (l_cpu_ready),
        .lcd_x       (l_lcd_x),
        .lcd_y       (l_lcd_y),
        .lcd_frame   (l_lcd_frame),
        .lcd_update  (l_lcd_update),
        .busy        (l_busy),
        .frame_count (l_frame_count)
    );

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", name, obs, exp);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int pulses, extra, busy_low, low, p1, p2, p3, bad;

        rst = 1'b1; cpu_we = 1'b0; cpu_clear = 1'b0; cpu_commit = 1'b0;
        cpu_x = '0; cpu_y = '0; cpu_color = '0; lcd_x = '0; lcd_y = '0;
        l_rst = 1'b1; l_cpu_we = 1'b0; l_cpu_clear = 1'b0; l_cpu_commit = 1'b0;
        l_cpu_x = '0; l_cpu_y = '0; l_cpu_color = '0; l_lcd_x = '0; l_lcd_y = '0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", cpu_ready, 0);
        check("rst_update", lcd_update, 0);
        check("rst_frame_count", frame_count, 0);
        check("rst_busy", busy, 1);

        // Boot holdoff: commit in cycle 3, pulse expected in cycle 10.
        rst = 1'b0;
        cyc = 0;
        #1;
        check("boot_ready", cpu_ready, 1);
        pulses = 0;
        while (cyc < 10) begin
            cpu_commit = (cyc == 3);
            pulses += int'(lcd_update);
            step();
        end
        cpu_commit = 1'b0;
        check("boot_no_early_pulse", pulses, 0);
        check("boot_pulse", lcd_update, 1);
        check("boot_frame_count", frame_count, 1);
        busy_low = 0;
        extra = 0;
        while (cyc < 36) begin
            busy_low += int'(!busy);
            if (cyc > 10) extra += int'(lcd_update);
            step();
        end
        check("boot_busy_through_gap", busy_low, 0);
        check("boot_single_pulse", extra, 0);
        check("idle_not_busy", busy, 0);

        // Pixel write and out-of-range write.
        lcd_x = 6'd5; lcd_y = 6'd2;
        #1;
        check("pre_write_read", lcd_frame, 0);
        cpu_we = 1'b1; cpu_x = 6'd5; cpu_y = 6'd2; cpu_color = 4'd9;
        step();
        check("write_visible_next_cycle", lcd_frame, 9);
        cpu_x = 6'd60; cpu_y = 6'd0; cpu_color = 4'd7;
        check("oob_write_ready", cpu_ready, 1);
        step();
        cpu_we = 1'b0;
        lcd_x = 6'd0; lcd_y = 6'd1;
        #1;
        check("oob_no_alias", lcd_frame, 0);

        // Clear with colour 4 and commit in the same cycle (cycle 38).
        cpu_clear = 1'b1; cpu_color = 4'd4; cpu_commit = 1'b1;
        step();
        cpu_clear = 1'b0; cpu_commit = 1'b0;
        low = 0;
        extra = 0;
        while (!cpu_ready && low < 3000) begin
            if (cyc == 41) begin
                lcd_x = 6'd1; lcd_y = 6'd0;
                #1;
                check("clear_addr1_reached", lcd_frame, 4);
                lcd_x = 6'd2;
                #1;
                check("clear_addr2_not_yet", lcd_frame, 0);
            end
            extra += int'(lcd_update);
            low++;
            step();
        end
        check("clear_ready_low_cycles", low, 1920);
        check("clear_no_pulse_during", extra, 0);
        check("clear_end_pulse", lcd_update, 1);
        check("clear_frame_count", frame_count, 2);

        // Two commits during SCAN collapse into one pulse 26 cycles later.
        p1 = cyc;
        repeat (3) step();
        cpu_commit = 1'b1;
        step();
        cpu_commit = 1'b0;
        repeat (4) step();
        cpu_commit = 1'b1;
        step();
        cpu_commit = 1'b0;
        while (!lcd_update && (cyc - p1) < 200) step();
        check("rescan_pulse_spacing", cyc - p1, 26);
        check("rescan_frame_count", frame_count, 3);
        p2 = cyc;
        extra = 0;
        repeat (40) begin
            step();
            extra += int'(lcd_update);
        end
        check("one_pulse_per_burst", extra, 0);
        check("after_burst_idle", cyc - p2, 40);

        // Commit in IDLE pulses on the following cycle.
        cpu_commit = 1'b1;
        step();
        cpu_commit = 1'b0;
        check("idle_commit_pulse", lcd_update, 1);
        check("idle_commit_frame_count", frame_count, 4);
        p3 = cyc;

        // Reset mid-scan with a pending commit.
        repeat (5) step();
        cpu_commit = 1'b1;
        step();
        cpu_commit = 1'b0;
        rst = 1'b1;
        #1;
        check("midscan_rst_ready", cpu_ready, 0);
        step();
        rst = 1'b0;
        cyc = 0;
        check("midscan_rst_frame_count", frame_count, 0);
        check("midscan_rst_update", lcd_update, 0);
        check("midscan_rst_busy", busy, 1);
        pulses = 0;
        while (cyc < 10) begin
            cpu_commit = (cyc == 2);
            pulses += int'(lcd_update);
            step();
        end
        cpu_commit = 1'b0;
        check("midscan_no_early_pulse", pulses, 0);
        check("midscan_reboot_pulse", lcd_update, 1);
        check("midscan_reboot_count", frame_count, 1);
        check("midscan_distinct_pulse", int'(p3 > 0), 1);

        // Whole framebuffer reads back the clear colour.
        bad = 0;
        for (int a = 0; a < 1920; a++) begin
            lcd_x = 6'(a % 60);
            lcd_y = 6'(a / 60);
            #1;
            if (lcd_frame !== 4'd4) bad++;
        end
        check("clear_all_addresses", bad, 0);

        // Scan lock on the second instance.
        @(posedge clk);
        #1;
        l_rst = 1'b0;
        cyc = 0;
        l_cpu_commit = 1'b1;
        step();
        l_cpu_commit = 1'b0;
        while (cyc < 10) step();
        check("lock_boot_pulse", l_lcd_update, 1);
        check("lock_idle_ready", l_cpu_ready, 1);
        while (cyc < 15) step();
        l_cpu_we = 1'b1; l_cpu_x = 6'd3; l_cpu_y = 6'd1; l_cpu_color = 4'd6;
        l_lcd_x = 6'd3; l_lcd_y = 6'd1;
        check("lock_scan_ready_low", l_cpu_ready, 0);
        while (!l_cpu_ready && cyc < 100) step();
        check("lock_first_ready_cycle", cyc, 31);
        check("lock_pre_write_read", l_lcd_frame, 0);
        step();
        l_cpu_we = 1'b0;
        check("lock_write_landed", l_lcd_frame, 6);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
